// File: rtl/mealy_seq_detector.sv
// Mealy run detector: z is high in any cycle where w=1 and the previous
// RUN_LEN-1 sampled values of w were also 1. The state is a saturating
// count of consecutive prior 1s. z is combinational on the current w, so a
// run is flagged in the same cycle its last 1 is presented.
module mealy_seq_detector #(
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8
) (
  input  logic             Clock,
  input  logic             Resetn,   // active-high asynchronous reset, despite the name
  input  logic             w,
  output logic             z,
  output logic [CNT_W-1:0] run_cnt
);

  // Terminal count: the number of prior 1s that arms detection.
  localparam logic [CNT_W-1:0] TERM = CNT_W'(RUN_LEN - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_term;

  // Count up while below the terminal count and hold there once reached.
  // Holding at TERM lets a sustained run of 1s keep z asserted every cycle,
  // which is how overlapping runs are detected.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] r;
    if (c >= TERM) begin
      r = TERM;
    end else begin
      r = c + CNT_W'(1);
    end
    return r;
  endfunction

  // Next-state logic: a 0 breaks the run; a 1 extends it, saturating.
  always_comb begin
    cnt_d = '0;
    if (w) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  // State register: reset clears the run immediately, without a clock.
  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_term = (cnt_q == TERM);

  // Mealy output: reset gates z low even for RUN_LEN=1, where at_term is
  // permanently true and z would otherwise simply follow w.
  assign z       = ~Resetn & w & at_term;
  assign run_cnt = cnt_q;

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Directed bench for mealy_seq_detector with RUN_LEN = 2, 3 and 1.
module tb_mealy_seq_detector;

  logic       clk;
  logic       rst;
  logic       w2, w3, w1;
  logic       z2, z3, z1;
  logic [7:0] cnt2, cnt3, cnt1;

  int n_checks = 0;
  int n_errors = 0;

  mealy_seq_detector #(.RUN_LEN(2), .CNT_W(8)) u_dut2 (
    .Clock(clk), .Resetn(rst), .w(w2), .z(z2), .run_cnt(cnt2)
  );
  mealy_seq_detector #(.RUN_LEN(3), .CNT_W(8)) u_dut3 (
    .Clock(clk), .Resetn(rst), .w(w3), .z(z3), .run_cnt(cnt3)
  );
  mealy_seq_detector #(.RUN_LEN(1), .CNT_W(8)) u_dut1 (
    .Clock(clk), .Resetn(rst), .w(w1), .z(z1), .run_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive w on the falling edge, check z before the rising edge, then check
  // run_cnt shortly after the rising edge.
  task automatic step(input int sel, input logic wv, input logic ez, input int ec, input string tag);
    @(negedge clk);
    case (sel)
      1:       w1 = wv;
      3:       w3 = wv;
      default: w2 = wv;
    endcase
    #1;
    case (sel)
      1:       chk({tag, ".z"}, {31'd0, z1}, {31'd0, ez});
      3:       chk({tag, ".z"}, {31'd0, z3}, {31'd0, ez});
      default: chk({tag, ".z"}, {31'd0, z2}, {31'd0, ez});
    endcase
    @(posedge clk);
    #1;
    case (sel)
      1:       chk({tag, ".cnt"}, {24'd0, cnt1}, ec);
      3:       chk({tag, ".cnt"}, {24'd0, cnt3}, ec);
      default: chk({tag, ".cnt"}, {24'd0, cnt2}, ec);
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    w1 = 1'b0; w2 = 1'b0; w3 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] seq_w, seq_z, seq_c;

  initial begin
    rst = 1'b1;
    w1 = 1'b1; w2 = 1'b1; w3 = 1'b1;

    // Reset state: outputs low even with w=1, including RUN_LEN=1.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.z2", {31'd0, z2}, 32'd0);
    chk("rst.z1", {31'd0, z1}, 32'd0);
    chk("rst.cnt2", {24'd0, cnt2}, 32'd0);
    chk("rst.cnt3", {24'd0, cnt3}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    w1 = 1'b0; w2 = 1'b0; w3 = 1'b0;

    // Idle with w=0.
    for (int i = 0; i < 3; i++) step(2, 1'b0, 1'b0, 0, "idle");

    // Pattern 0,1,1,0,0,1,1,0 (element i at bit 7-i).
    seq_w = 8'b0110_0110;
    seq_z = 8'b0010_0010;
    seq_c = 8'b0110_0110;
    for (int i = 7; i >= 0; i--) step(2, seq_w[i], seq_z[i], int'(seq_c[i]), "pat2");

    // Sustained 1s: z from the second cycle, count saturates at 1.
    step(2, 1'b1, 1'b0, 1, "hold2");
    for (int i = 0; i < 4; i++) step(2, 1'b1, 1'b1, 1, "hold2");

    // Asynchronous reset mid-cycle while in B with w=1.
    @(negedge clk);
    w2 = 1'b1;
    #1;
    chk("arst.pre.z", {31'd0, z2}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst.z", {31'd0, z2}, 32'd0);
    chk("arst.cnt", {24'd0, cnt2}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst.rel.z", {31'd0, z2}, 32'd0);
    @(posedge clk);
    #1;
    chk("arst.rel.cnt", {24'd0, cnt2}, 32'd1);
    step(2, 1'b1, 1'b1, 1, "arst.after");

    // RUN_LEN=3: w=1,1,0,1,1,1,1 -> z=0,0,0,0,0,1,1.
    do_reset();
    step(3, 1'b1, 1'b0, 1, "r3");
    step(3, 1'b1, 1'b0, 2, "r3");
    step(3, 1'b0, 1'b0, 0, "r3");
    step(3, 1'b1, 1'b0, 1, "r3");
    step(3, 1'b1, 1'b0, 2, "r3");
    step(3, 1'b1, 1'b1, 2, "r3");
    step(3, 1'b1, 1'b1, 2, "r3");

    // RUN_LEN=1: z mirrors w, count stays 0.
    do_reset();
    step(1, 1'b0, 1'b0, 0, "r1");
    step(1, 1'b1, 1'b1, 0, "r1");
    step(1, 1'b0, 1'b0, 0, "r1");
    step(1, 1'b1, 1'b1, 0, "r1");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("r1.rst.z", {31'd0, z1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
